conv_out_quant: RTL and testbench

CONV_OUT_QUANT -- requirements
Module: conv_out_quant

---
 rtl/conv_out_quant.sv | 137 +++++++++++++
 tb/tb_conv_out_quant.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_quant.sv
// conv_out_quant
//   Quantizes the signed results of an upstream 1-D convolver to OUT_WIDTH bits
//   and buffers them in a 2-entry output FIFO.
//   Quantization: optional ReLU, round-half-up arithmetic right shift by SHIFT,
//   then saturation to the signed OUT_WIDTH range (counted in sat_count).
//   Each result is tagged with a frame "last" flag on index NUM_OUT-1.
//
// Ports
//   clk           : clock, all state on rising edge
//   reset         : synchronous active-low reset
//   s_valid_y     : upstream result valid
//   s_data_in_y   : signed convolution result [ACC_SIZE]
//   s_ready_y     : block can accept a result (registered state only)
//   m_valid_z     : quantized output valid
//   m_ready_z     : downstream accepts output
//   m_data_out_z  : signed quantized output [OUT_WIDTH]
//   m_last_z      : final output of a frame
//   sat_count     : saturating count of clamped results since reset
module conv_out_quant #(
    parameter int ACC_SIZE  = 21,
    parameter int OUT_WIDTH = 8,
    parameter int SHIFT     = 4,
    parameter int NUM_OUT   = 97,
    parameter int RELU_EN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid_y,
    input  logic [ACC_SIZE-1:0]  s_data_in_y,
    output logic                 s_ready_y,
    output logic                 m_valid_z,
    input  logic                 m_ready_z,
    output logic [OUT_WIDTH-1:0] m_data_out_z,
    output logic                 m_last_z,
    output logic [15:0]          sat_count
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    // Rounding constant and clamp thresholds, all in ACC_SIZE+1 bits so the
    // rounding add cannot overflow.
    localparam logic [ACC_SIZE:0]        HALF  = (ACC_SIZE+1)'(1) << (SHIFT-1);
    localparam logic signed [ACC_SIZE:0] MAXV  = (ACC_SIZE+1)'((2**(OUT_WIDTH-1)) - 1);
    localparam logic signed [ACC_SIZE:0] MINV  = ~MAXV;
    localparam logic [OUT_WIDTH-1:0]     OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]     OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    // ---------------- quantizer (combinational, at push time) ----------------
    logic signed [ACC_SIZE:0] in_ext;
    logic signed [ACC_SIZE:0] rnd;
    logic signed [ACC_SIZE:0] shifted;
    logic [OUT_WIDTH-1:0]     q_data;
    logic                     q_sat;
    logic                     q_last;

    assign in_ext  = $signed({s_data_in_y[ACC_SIZE-1], s_data_in_y});
    assign rnd     = in_ext + $signed(HALF);
    assign shifted = rnd >>> SHIFT;

    always_comb begin
        q_sat  = 1'b0;
        q_data = shifted[OUT_WIDTH-1:0];
        if ((RELU_EN != 0) && in_ext[ACC_SIZE]) begin
            // ReLU zeroing is not a saturation event
            q_data = '0;
        end else if (shifted > MAXV) begin
            q_data = OUT_MAX;
            q_sat  = 1'b1;
        end else if (shifted < MINV) begin
            q_data = OUT_MIN;
            q_sat  = 1'b1;
        end
    end

    // ---------------- state ----------------
    logic [OUT_WIDTH-1:0] data_q [2];
    logic [1:0]           last_q;
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [1:0]           cnt_q,  cnt_d;
    logic [IDX_W-1:0]     idx_q,  idx_d;
    logic [15:0]          sat_q,  sat_d;
    logic                 push, pop;

    assign q_last = (idx_q == IDX_W'(NUM_OUT-1));

    // Outputs are gated by reset so that they read as idle for the whole
    // time reset is held, not just from the first reset edge onward.
    assign s_ready_y    = reset & (cnt_q != 2'd2);
    assign m_valid_z    = reset & (cnt_q != 2'd0);
    assign m_data_out_z = m_valid_z ? data_q[rptr_q] : '0;
    assign m_last_z     = m_valid_z & last_q[rptr_q];
    assign sat_count    = sat_q;

    assign push = s_valid_y & s_ready_y;
    assign pop  = m_valid_z & m_ready_z;

    always_comb begin
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        idx_d  = idx_q;
        sat_d  = sat_q;
        if (push && !pop)      cnt_d = cnt_q + 2'd1;
        else if (pop && !push) cnt_d = cnt_q - 2'd1;
        if (push) begin
            wptr_d = ~wptr_q;
            idx_d  = q_last ? '0 : idx_q + IDX_W'(1);
            if (q_sat && (sat_q != 16'hFFFF)) sat_d = sat_q + 16'd1;
        end
        if (pop) rptr_d = ~rptr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            idx_q     <= '0;
            sat_q     <= '0;
            last_q    <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            idx_q  <= idx_d;
            sat_q  <= sat_d;
            if (push) begin
                data_q[wptr_q] <= q_data;
                last_q[wptr_q] <= q_last;
            end
        end
    end

endmodule

// File: tb/tb_conv_out_quant.sv
// Scoreboard bench: two instances (ReLU on / ReLU off) share stimulus and
// output handshake; a reference model from the quantization rules predicts
// both streams, the frame tags and the saturation counters.
module tb_conv_out_quant;
    localparam int ACC = 21;
    localparam int OW  = 8;
    localparam int SH  = 4;
    localparam int NO  = 97;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           s_valid = 1'b0;
    logic [ACC-1:0] s_data = '0;
    logic           m_ready = 1'b0;

    logic           rdy0, rdy1, vld0, vld1, last0, last1;
    logic [OW-1:0]  dat0, dat1;
    logic [15:0]    satc0, satc1;

    conv_out_quant #(.ACC_SIZE(ACC), .OUT_WIDTH(OW), .SHIFT(SH), .NUM_OUT(NO), .RELU_EN(1)) u0 (
        .clk(clk), .reset(reset), .s_valid_y(s_valid), .s_data_in_y(s_data), .s_ready_y(rdy0),
        .m_valid_z(vld0), .m_ready_z(m_ready), .m_data_out_z(dat0), .m_last_z(last0), .sat_count(satc0));

    conv_out_quant #(.ACC_SIZE(ACC), .OUT_WIDTH(OW), .SHIFT(SH), .NUM_OUT(NO), .RELU_EN(0)) u1 (
        .clk(clk), .reset(reset), .s_valid_y(s_valid), .s_data_in_y(s_data), .s_ready_y(rdy1),
        .m_valid_z(vld1), .m_ready_z(m_ready), .m_data_out_z(dat1), .m_last_z(last1), .sat_count(satc1));

    always #5 clk = ~clk;

    typedef struct { int d0; int d1; bit last; } exp_t;
    exp_t q[$];

    int cmp = 0, bad = 0;
    int idx = 0, sat0 = 0, sat1 = 0;
    int mode = 0;   // 0: always ready, 1: random ready, 2: stalled

    task automatic chk(string nm, int act, int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: ReLU, round half up of x/2^SH, clamp to signed OW range.
    function automatic int ref_q(int x, bit relu, output bit sat);
        int v;
        sat = 1'b0;
        if (relu && x < 0) return 0;
        v = int'($floor(real'(x) / real'(2**SH) + 0.5));
        if (v > 2**(OW-1) - 1) begin sat = 1'b1; v = 2**(OW-1) - 1; end
        else if (v < -(2**(OW-1))) begin sat = 1'b1; v = -(2**(OW-1)); end
        return v;
    endfunction

    function automatic int rnd_in();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 600)) - 300;
            1: return int'($urandom_range(1900, 2200)) * (($urandom_range(0, 1) != 0) ? 1 : -1);
            2: return int'($urandom_range(0, 2**ACC - 1)) - 2**(ACC-1);
            default: return int'($urandom_range(0, 4200)) - 2100;
        endcase
    endfunction

    // Offer one result; on acceptance record the expected output.
    task automatic send(int x);
        bit ok = 1'b0;
        bit s0, s1;
        exp_t e;
        s_valid = 1'b1;
        s_data  = ACC'(x);
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            if (rdy0 && reset) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        e.d0   = ref_q(x, 1'b1, s0);
        e.d1   = ref_q(x, 1'b0, s1);
        e.last = (idx == NO - 1);
        idx    = (idx == NO - 1) ? 0 : idx + 1;
        if (s0 && sat0 < 65535) sat0++;
        if (s1 && sat1 < 65535) sat1++;
        q.push_back(e);
    endtask

    task automatic do_reset(int cyc);
        reset   = 1'b0;
        s_valid = 1'b0;
        q.delete();
        idx  = 0;
        sat0 = 0;
        sat1 = 0;
        repeat (cyc) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic drain();
        mode = 0;
        for (int i = 0; i < 500 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_left", q.size(), 0);
    endtask

    // Downstream ready generator
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 2) != 0);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: occupancy, counters and in-order output comparison
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_s_ready", int'(rdy0), 0);
            chk("rst_m_valid", int'(vld0), 0);
            chk("rst_m_data",  int'(dat0), 0);
            chk("rst_m_last",  int'(last0), 0);
        end else begin
            chk("s_ready0", int'(rdy0), int'(q.size() < 2));
            chk("s_ready1", int'(rdy1), int'(q.size() < 2));
            chk("m_valid0", int'(vld0), int'(q.size() > 0));
            chk("m_valid1", int'(vld1), int'(q.size() > 0));
            chk("sat_count0", int'(satc0), sat0);
            chk("sat_count1", int'(satc1), sat1);
            if (vld0 && m_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data_relu",   int'($signed(dat0)), e.d0);
                    chk("data_norelu", int'($signed(dat1)), e.d1);
                    chk("last0", int'(last0), int'(e.last));
                    chk("last1", int'(last1), int'(e.last));
                end
            end
        end
    end

    initial begin
        do_reset(3);

        // directed rounding / saturation / sign cases
        mode = 0;
        send(56); send(2000); send(7); send(2040); send(-3000); send(-100);
        drain();

        // backpressure: two accepted, third held until ready returns
        mode = 2;
        repeat (3) @(posedge clk);
        #1;
        send(300); send(-500);
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_s_ready_held", int'(rdy0), 0);
                mode = 0;
            end
        join_none
        send(1234);
        drain();

        // random traffic with random downstream ready
        mode = 1;
        for (int i = 0; i < 150; i++) send(rnd_in());
        drain();

        // frame tagging from a clean reset: 98 results
        do_reset(1);
        mode = 0;
        for (int i = 0; i < 98; i++) send(rnd_in());
        drain();

        // mid-frame reset with two outputs pending
        do_reset(1);
        for (int i = 0; i < 40; i++) send(rnd_in());
        drain();
        mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send(2040); send(-3000);
        do_reset(1);
        mode = 1;
        for (int i = 0; i < 100; i++) send(rnd_in());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
